// File: rtl/mem_sync_initiator.sv
// mem_sync_initiator: serializing controller for a single-port synchronous
// memory (write priority, registered read data that holds during writes).
// Requests arrive on a valid/ready channel. Read data returns on a
// valid/ready response channel. All memory-side pins are registered.
// Optional build macro MEM_INIT_CLEAR_EN: after reset, zero-fill every
// memory word before accepting requests.
module mem_sync_initiator #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  init_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    RSP
`ifdef MEM_INIT_CLEAR_EN
    , CLEAR
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef MEM_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q, init_done_d;
  localparam state_e RST_STATE = CLEAR;
  assign init_done = init_done_q;
`else
  localparam state_e RST_STATE = IDLE;
  assign init_done = 1'b1;
`endif

  assign req_ready  = (state_q == IDLE) && init_done;
  assign busy       = (state_q != IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_w = mem_data_w_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

  // State and output registers; reset drops mem_we immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_w_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
`ifdef MEM_INIT_CLEAR_EN
      clr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_w_q <= mem_data_w_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef MEM_INIT_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
      init_done_q  <= init_done_d;
`endif
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef MEM_INIT_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          mem_addr_d = req_addr;
          mem_we_d   = req_we;
          if (req_we) mem_data_w_d = req_wdata;
          state_d    = ISSUE;
        end
      end
      // Memory acts on the closing edge of this cycle.
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = mem_we_q ? IDLE : CAPT;
      end
      // Registered read data is now on mem_data_r.
      CAPT: begin
        rsp_rdata_d = mem_data_r;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef MEM_INIT_CLEAR_EN
      // Zero-fill: finish once the top address write is on the pins.
      CLEAR: begin
        if (mem_we_q && (mem_addr_q == {ADDR_WIDTH{1'b1}})) begin
          mem_we_d    = 1'b0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_we_d     = 1'b1;
          mem_addr_d   = clr_cnt_q;
          mem_data_w_d = '0;
          clr_cnt_d    = clr_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule
